pic_priority_engine: RTL and testbench
======================================

Name: pic_priority_engine

Overview:
Clocked, parametrised successor of the interrupt priority resolver for the 8259A-style PIC. It holds IRR/ISR/IMR for N_IRQ request lines and supports edge or level triggering, fixed or rotating priority, fully-nested masking against in-service levels, a two-pulse INTA handshake, OCW2-style EOI/rotate commands and AEOI with optional rotation. It sits between the IR pins and the control logic / read-write logic, in a single clock domain.

Parameters:
N_IRQ, 8, number of interrupt request lines (power of two, 2..32)
IDX_W, $clog2(N_IRQ), width of an IRQ index

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
ir  in  N_IRQ  raw request lines, already synchronous to clk
level_mode  in  1  1 = level triggered, 0 = rising-edge triggered (ICW1 LTIM)
aeoi  in  1  automatic EOI enable (ICW4)
imr_wr  in  1  one-cycle strobe: load IMR (OCW1)
imr_wdata  in  N_IRQ  new mask value
cmd_valid  in  1  one-cycle strobe: execute OCW2 command
cmd_op  in  3  {R,SL,EOI}
cmd_level  in  IDX_W  level field L for specific commands
inta_n  in  1  CPU acknowledge, active low, synchronous to clk
int_o  out  1  interrupt request to CPU, registered
vec_valid  out  1  one-cycle pulse on the second INTA falling edge
vec_idx  out  IDX_W  acknowledged index, valid with vec_valid, held afterwards
irr  out  N_IRQ  interrupt request register
isr  out  N_IRQ  in-service register
imr  out  N_IRQ  interrupt mask register
lowest_prio  out  IDX_W  index currently holding lowest priority

Behaviour:
- Reset (rst_n=0 at a clk edge): irr=0, isr=0, imr=0, lowest_prio=N_IRQ-1 (fixed order, 0 highest), rot_aeoi=0, state=IDLE, int_o=0, vec_valid=0, vec_idx=0, ir_q=0. Reset mid-handshake abandons it; no vector is issued.
- Priority order: index (lowest_prio+1) mod N_IRQ is highest, descending with wrap to lowest_prio.
- IRR: edge mode sets irr[i] when ir[i]=1 and ir_q[i]=0; a bit stays set until acknowledged, even if ir drops. Level mode: irr[i] follows ir[i] every cycle, except that the bit chosen by ACK1 is cleared that cycle.
- pending = irr & ~imr. best_req = highest-priority pending bit; best_isr = highest-priority isr bit.
- int_o (registered): 1 iff pending≠0 and (isr=0 or best_req has strictly higher priority than best_isr). One-cycle latency from irr/imr/isr change to int_o.
- INTA falling edge = inta_n=0 with previous sample 1. FSM states IDLE, WAIT2.
- IDLE + falling edge (ACK1): if pending≠0, set isr[best_req], clear irr[best_req], latch ack_idx=best_req; otherwise spurious: ack_idx=N_IRQ-1, isr unchanged. Go to WAIT2.
- WAIT2 + falling edge (ACK2): vec_valid=1 for one cycle, vec_idx=ack_idx. If aeoi and not spurious, clear isr[ack_idx]; if rot_aeoi as well, lowest_prio=ack_idx. Go to IDLE.
- Commands (cmd_valid=1), cmd_op: 001 non-specific EOI: clear isr[best_isr] (no-op if isr=0). 011 specific EOI: clear isr[cmd_level]. 101 rotate on non-specific EOI: as 001, then lowest_prio=best_isr (no change if isr=0). 111 rotate on specific EOI: clear isr[cmd_level], lowest_prio=cmd_level. 110 set priority: lowest_prio=cmd_level. 100 set rot_aeoi. 000 clear rot_aeoi. 010 no-op.
- Same-cycle collisions: a command evaluates best_isr from the pre-cycle isr; an ACK1 set of isr bit k wins over a command clear of the same bit k. An ACK2 AEOI rotate and a command write to lowest_prio in the same cycle: the command wins. imr_wr takes effect next cycle, and ACK1 in the same cycle uses the old imr.
- lowest_prio arithmetic is modulo N_IRQ and wraps with no error.

Decomposition:
- pic_pkg: OCW2 opcode constants (OP_NSEOI, OP_SEOI, OP_ROT_NSEOI, OP_ROT_SEOI, OP_SET_PRIO, OP_ROT_AEOI_SET, OP_ROT_AEOI_CLR), FSM state enum (IDLE, WAIT2).
- Sub-module pic_rot_prio_sel (combinational, parameter N_IRQ): inputs vector and lowest_prio, outputs found and idx of the highest-priority set bit. Instantiated twice (pending, isr).

Test Plan:
- Fixed priority: imr=0, pulse ir[5] and ir[2] together, then two INTA pulses -> ack1 isr=0x04 and irr=0x20; ack2 vec_idx=2 with vec_valid for exactly one cycle; int_o stays 0 until non-specific EOI, then rises again for IR5.
- Nesting/mask: isr=0x04 in service, raise ir[6] -> int_o=0; raise ir[1] -> int_o=1 one cycle later; imr_wr 0x02 -> int_o=0 the next cycle.
- Rotation: cmd 110 with L=3, then ir[2] and ir[4] pending -> ACK selects 4; cmd 101 -> isr=0, lowest_prio=4, next ACK selects 2.
- AEOI with rotation: aeoi=1, cmd 100, ir[0] -> after ACK2 isr=0 and lowest_prio=0; a repeat on ir[0]/ir[1] selects 1 first.
- Spurious and edge/level: ir[3] pulse that is masked before ACK1 -> vec_idx=7 and isr unchanged; level_mode=1 with ir[3] dropped before ACK -> irr[3]=0; edge mode holds irr[3]=1.
- Reset mid-handshake: rst_n low in WAIT2 -> all registers return to reset values and no vec_valid; collision test: ACK1 and cmd 011 L=best_req in the same cycle -> isr bit remains set.

Source files
------------

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the PIC priority engine:
//   - OCW2 command opcodes, encoded as {R, SL, EOI}
//   - handshake FSM state type (IDLE waits for the first INTA edge,
//     WAIT2 waits for the second one that delivers the vector)
// ---------------------------------------------------------------------------
package pic_pkg;

  localparam logic [2:0] OP_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OP_NSEOI        = 3'b001;
  localparam logic [2:0] OP_NOP          = 3'b010;
  localparam logic [2:0] OP_SEOI         = 3'b011;
  localparam logic [2:0] OP_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OP_ROT_NSEOI    = 3'b101;
  localparam logic [2:0] OP_SET_PRIO     = 3'b110;
  localparam logic [2:0] OP_ROT_SEOI     = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } pic_state_e;

endpackage

// File: rtl/pic_rot_prio_sel.sv
// ---------------------------------------------------------------------------
// pic_rot_prio_sel
// Combinational rotating-priority selector. The bit just above lowest_prio
// (modulo N_IRQ) is the highest priority, and priority descends with
// wrap-around until lowest_prio itself, which is the lowest.
// Ports:
//   vec          in  N_IRQ  candidate bits
//   lowest_prio  in  IDX_W  index currently holding lowest priority
//   found        out 1      at least one bit of vec is set
//   idx          out IDX_W  index of the highest-priority set bit (0 if none)
// ---------------------------------------------------------------------------
module pic_rot_prio_sel #(
  parameter int N_IRQ = 8,
  parameter int IDX_W = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] vec,
  input  logic [IDX_W-1:0] lowest_prio,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk the bits in priority order starting just above lowest_prio; the
  // first set bit wins. Because N_IRQ is a power of two, the IDX_W-wide
  // addition wraps modulo N_IRQ on its own, and k = N_IRQ lands back on
  // lowest_prio, which is visited last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_IRQ; k++) begin
      cand = lowest_prio + IDX_W'(k);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pic_priority_engine.sv
// ---------------------------------------------------------------------------
// pic_priority_engine
// Clocked 8259A-style interrupt priority resolver. Holds IRR/ISR/IMR, does
// edge or level capture, fixed or rotating priority, fully-nested masking
// against in-service levels, the two-pulse INTA handshake, OCW2 EOI/rotate
// commands and AEOI with optional rotation.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   ir                raw request lines (already synchronous)
//   level_mode        1 = level triggered, 0 = rising-edge triggered
//   aeoi              automatic EOI on the second INTA edge
//   imr_wr/imr_wdata  one-cycle strobe loading the mask register
//   cmd_valid/cmd_op/cmd_level  one-cycle OCW2 command {R,SL,EOI} and level
//   inta_n            CPU acknowledge, active low
//   int_o             registered interrupt request to the CPU
//   vec_valid/vec_idx acknowledged index, pulsed on the second INTA edge
//   irr/isr/imr       request, in-service and mask registers
//   lowest_prio       index currently holding lowest priority
// ---------------------------------------------------------------------------
module pic_priority_engine
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int IDX_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] ir,
  input  logic             level_mode,
  input  logic             aeoi,
  input  logic             imr_wr,
  input  logic [N_IRQ-1:0] imr_wdata,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_level,
  input  logic             inta_n,
  output logic             int_o,
  output logic             vec_valid,
  output logic [IDX_W-1:0] vec_idx,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr,
  output logic [N_IRQ-1:0] imr,
  output logic [IDX_W-1:0] lowest_prio
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IRQ - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  pic_state_e       state;
  logic [N_IRQ-1:0] ir_q;
  logic             inta_q;
  logic             rot_aeoi;
  logic [IDX_W-1:0] ack_idx;
  logic             ack_spurious;

  logic [N_IRQ-1:0] pending;
  logic             pend_found;
  logic [IDX_W-1:0] best_req;
  logic             isr_found;
  logic [IDX_W-1:0] best_isr;
  logic [IDX_W-1:0] req_rank;
  logic [IDX_W-1:0] isr_rank;
  logic             inta_fall;
  logic             ack1;
  logic             ack2;
  logic             int_nxt;

  logic [N_IRQ-1:0] irr_nxt;
  logic [N_IRQ-1:0] isr_nxt;
  logic [IDX_W-1:0] lowest_nxt;
  logic             rot_aeoi_nxt;

  assign pending = irr & ~imr;

  pic_rot_prio_sel #(
    .N_IRQ (N_IRQ),
    .IDX_W (IDX_W)
  ) u_req_sel (
    .vec         (pending),
    .lowest_prio (lowest_prio),
    .found       (pend_found),
    .idx         (best_req)
  );

  pic_rot_prio_sel #(
    .N_IRQ (N_IRQ),
    .IDX_W (IDX_W)
  ) u_isr_sel (
    .vec         (isr),
    .lowest_prio (lowest_prio),
    .found       (isr_found),
    .idx         (best_isr)
  );

  // Rank 0 is the highest priority. Rebasing each index against the bit
  // just above lowest_prio turns "strictly higher priority" into a plain
  // unsigned less-than, with the modulo wrap handled by the IDX_W width.
  assign req_rank  = best_req - lowest_prio - ONE_IDX;
  assign isr_rank  = best_isr - lowest_prio - ONE_IDX;
  assign int_nxt   = pend_found && (!isr_found || (req_rank < isr_rank));

  assign inta_fall = inta_q && !inta_n;
  assign ack1      = inta_fall && (state == IDLE);
  assign ack2      = inta_fall && (state == WAIT2);

  // Next-value logic for IRR, ISR, lowest_prio and the rotate-on-AEOI flag.
  // The ordering of the statements encodes the collision rules: command
  // writes come after the AEOI rotate so the command wins lowest_prio, and
  // the ACK1 set of ISR comes last so it beats any command clear of the
  // same bit. Commands look at best_isr computed from the current ISR.
  always_comb begin
    irr_nxt      = level_mode ? ir : (irr | (ir & ~ir_q));
    isr_nxt      = isr;
    lowest_nxt   = lowest_prio;
    rot_aeoi_nxt = rot_aeoi;

    if (ack1 && pend_found) begin
      irr_nxt[best_req] = 1'b0;
    end

    if (ack2 && aeoi && !ack_spurious) begin
      isr_nxt[ack_idx] = 1'b0;
      if (rot_aeoi) begin
        lowest_nxt = ack_idx;
      end
    end

    if (cmd_valid) begin
      case (cmd_op)
        OP_NSEOI: begin
          if (isr_found) begin
            isr_nxt[best_isr] = 1'b0;
          end
        end
        OP_SEOI: begin
          isr_nxt[cmd_level] = 1'b0;
        end
        OP_ROT_NSEOI: begin
          if (isr_found) begin
            isr_nxt[best_isr] = 1'b0;
            lowest_nxt        = best_isr;
          end
        end
        OP_ROT_SEOI: begin
          isr_nxt[cmd_level] = 1'b0;
          lowest_nxt         = cmd_level;
        end
        OP_SET_PRIO:     lowest_nxt   = cmd_level;
        OP_ROT_AEOI_SET: rot_aeoi_nxt = 1'b1;
        OP_ROT_AEOI_CLR: rot_aeoi_nxt = 1'b0;
        OP_NOP:          ;
        default:         ;
      endcase
    end

    if (ack1 && pend_found) begin
      isr_nxt[best_req] = 1'b1;
    end
  end

  // All state lives here: the register file, the input history used for
  // edge detection, the registered int_o, and the INTA handshake FSM.
  // ACK1 latches the winning index (or the spurious index N_IRQ-1 when
  // nothing is pending); ACK2 presents it as a one-cycle vector pulse.
  // Reset in WAIT2 simply drops the handshake without issuing a vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irr          <= '0;
      isr          <= '0;
      imr          <= '0;
      lowest_prio  <= LAST_IDX;
      rot_aeoi     <= 1'b0;
      state        <= IDLE;
      int_o        <= 1'b0;
      vec_valid    <= 1'b0;
      vec_idx      <= '0;
      ir_q         <= '0;
      inta_q       <= 1'b1;
      ack_idx      <= '0;
      ack_spurious <= 1'b0;
    end else begin
      irr         <= irr_nxt;
      isr         <= isr_nxt;
      lowest_prio <= lowest_nxt;
      rot_aeoi    <= rot_aeoi_nxt;
      ir_q        <= ir;
      inta_q      <= inta_n;
      int_o       <= int_nxt;
      vec_valid   <= 1'b0;
      if (imr_wr) begin
        imr <= imr_wdata;
      end
      case (state)
        IDLE: begin
          if (inta_fall) begin
            ack_idx      <= pend_found ? best_req : LAST_IDX;
            ack_spurious <= !pend_found;
            state        <= WAIT2;
          end
        end
        WAIT2: begin
          if (inta_fall) begin
            vec_valid <= 1'b1;
            vec_idx   <= ack_idx;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_priority_engine.sv
// ---------------------------------------------------------------------------
// tb_pic_priority_engine
// Directed bench for pic_priority_engine (N_IRQ = 8). Stimulus tasks push
// hand-computed expectations into queues; a separate monitor process owns
// every comparison: it matches each vec_valid pulse against the next
// expected vector and drains queued register checks.
// ---------------------------------------------------------------------------
module tb_pic_priority_engine;
  import pic_pkg::*;

  localparam int N_IRQ = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_IRQ-1:0] ir;
  logic             level_mode;
  logic             aeoi;
  logic             imr_wr;
  logic [N_IRQ-1:0] imr_wdata;
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [IDX_W-1:0] cmd_level;
  logic             inta_n;
  logic             int_o;
  logic             vec_valid;
  logic [IDX_W-1:0] vec_idx;
  logic [N_IRQ-1:0] irr;
  logic [N_IRQ-1:0] isr;
  logic [N_IRQ-1:0] imr;
  logic [IDX_W-1:0] lowest_prio;

  int          expVecQ[$];
  string       chkNameQ[$];
  logic [31:0] chkActQ[$];
  logic [31:0] chkExpQ[$];
  int          compared = 0;
  int          mismatched = 0;

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  pic_priority_engine #(
    .N_IRQ (N_IRQ),
    .IDX_W (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir          (ir),
    .level_mode  (level_mode),
    .aeoi        (aeoi),
    .imr_wr      (imr_wr),
    .imr_wdata   (imr_wdata),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_level   (cmd_level),
    .inta_n      (inta_n),
    .int_o       (int_o),
    .vec_valid   (vec_valid),
    .vec_idx     (vec_idx),
    .irr         (irr),
    .isr         (isr),
    .imr         (imr),
    .lowest_prio (lowest_prio)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    chkNameQ.push_back(name);
    chkActQ.push_back(act);
    chkExpQ.push_back(exp);
  endtask

  task automatic applyStimulus(input logic [N_IRQ-1:0] irv, input int cycles);
    ir = irv;
    tick(cycles);
  endtask

  task automatic pulseIr(input logic [N_IRQ-1:0] m);
    applyStimulus(m, 1);
    applyStimulus('0, 1);
  endtask

  task automatic intaPulse();
    inta_n = 1'b0;
    tick(1);
    inta_n = 1'b1;
    tick(1);
  endtask

  task automatic ackCycle(input int expIdx);
    intaPulse();
    expVecQ.push_back(expIdx);
    intaPulse();
  endtask

  task automatic sendCmd(input logic [2:0] op, input logic [IDX_W-1:0] lvl);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_level = lvl;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic writeImr(input logic [N_IRQ-1:0] m);
    imr_wr    = 1'b1;
    imr_wdata = m;
    tick(1);
    imr_wr    = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge. Any
  // vec_valid without an outstanding expectation is a failure, which also
  // catches pulses longer than one cycle and vectors issued after reset.
  initial begin
    int    e;
    string nm;
    logic [31:0] a;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && vec_valid === 1'b1) begin
        compared++;
        if (expVecQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_vec_valid: got vec_idx=%0d, required no vector", vec_idx);
        end else begin
          e = expVecQ.pop_front();
          if (int'(vec_idx) != e) begin
            mismatched++;
            $display("[TB] FAIL vec_idx: got %0d, required %0d", vec_idx, e);
          end
        end
      end
      while (chkNameQ.size() > 0) begin
        nm = chkNameQ.pop_front();
        a  = chkActQ.pop_front();
        x  = chkExpQ.pop_front();
        compared++;
        if (a !== x) begin
          mismatched++;
          $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", nm, a, x);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    ir         = '0;
    level_mode = 1'b0;
    aeoi       = 1'b0;
    imr_wr     = 1'b0;
    imr_wdata  = '0;
    cmd_valid  = 1'b0;
    cmd_op     = OP_NOP;
    cmd_level  = '0;
    inta_n     = 1'b1;
    tick(1);
    doReset();

    $display("[TB] reset values");
    checkOutput("rst_irr", irr, 0);
    checkOutput("rst_isr", isr, 0);
    checkOutput("rst_imr", imr, 0);
    checkOutput("rst_lowest_prio", lowest_prio, 7);
    checkOutput("rst_int_o", int_o, 0);
    checkOutput("rst_vec_valid", vec_valid, 0);
    checkOutput("rst_vec_idx", vec_idx, 0);

    $display("[TB] fixed priority");
    pulseIr(8'h24);
    checkOutput("fp_irr", irr, 32'h24);
    checkOutput("fp_int_o_req", int_o, 1);
    intaPulse();
    checkOutput("fp_ack1_isr", isr, 32'h04);
    checkOutput("fp_ack1_irr", irr, 32'h20);
    checkOutput("fp_ack1_int_o", int_o, 0);
    expVecQ.push_back(2);
    intaPulse();
    checkOutput("fp_ack2_isr", isr, 32'h04);
    checkOutput("fp_ack2_int_o", int_o, 0);
    checkOutput("fp_vec_valid_low", vec_valid, 0);
    sendCmd(OP_NSEOI, 3'd0);
    checkOutput("fp_eoi_isr", isr, 0);
    tick(1);
    checkOutput("fp_eoi_int_o", int_o, 1);

    $display("[TB] nesting and mask");
    doReset();
    pulseIr(8'h04);
    ackCycle(2);
    checkOutput("nm_isr", isr, 32'h04);
    pulseIr(8'h40);
    checkOutput("nm_irr6", irr, 32'h40);
    checkOutput("nm_int_o_low_prio", int_o, 0);
    applyStimulus(8'h02, 1);
    checkOutput("nm_int_o_latency", int_o, 0);
    applyStimulus(8'h00, 1);
    checkOutput("nm_int_o_high_prio", int_o, 1);
    writeImr(8'h02);
    checkOutput("nm_imr", imr, 32'h02);
    tick(1);
    checkOutput("nm_int_o_masked", int_o, 0);

    $display("[TB] rotation");
    doReset();
    sendCmd(OP_SET_PRIO, 3'd3);
    checkOutput("rot_set_prio", lowest_prio, 3);
    pulseIr(8'h14);
    ackCycle(4);
    checkOutput("rot_isr", isr, 32'h10);
    checkOutput("rot_irr", irr, 32'h04);
    sendCmd(OP_ROT_NSEOI, 3'd0);
    checkOutput("rot_nseoi_isr", isr, 0);
    checkOutput("rot_nseoi_lowest", lowest_prio, 4);
    ackCycle(2);
    checkOutput("rot_second_isr", isr, 32'h04);

    $display("[TB] aeoi with rotation");
    doReset();
    aeoi = 1'b1;
    sendCmd(OP_ROT_AEOI_SET, 3'd0);
    pulseIr(8'h01);
    ackCycle(0);
    checkOutput("aeoi_isr", isr, 0);
    checkOutput("aeoi_lowest", lowest_prio, 0);
    pulseIr(8'h03);
    ackCycle(1);
    checkOutput("aeoi2_lowest", lowest_prio, 1);
    checkOutput("aeoi2_irr", irr, 32'h01);
    checkOutput("aeoi2_isr", isr, 0);
    ackCycle(0);
    checkOutput("aeoi3_lowest", lowest_prio, 0);
    checkOutput("aeoi3_irr", irr, 0);
    aeoi = 1'b0;

    $display("[TB] spurious and trigger modes");
    doReset();
    pulseIr(8'h08);
    writeImr(8'h08);
    ackCycle(7);
    checkOutput("spur_isr", isr, 0);
    checkOutput("spur_irr", irr, 32'h08);
    doReset();
    level_mode = 1'b1;
    applyStimulus(8'h08, 1);
    checkOutput("lvl_irr_high", irr, 32'h08);
    applyStimulus(8'h00, 1);
    checkOutput("lvl_irr_dropped", irr, 0);
    ackCycle(7);
    checkOutput("lvl_isr", isr, 0);
    doReset();
    level_mode = 1'b0;
    pulseIr(8'h08);
    tick(2);
    checkOutput("edge_irr_held", irr, 32'h08);

    $display("[TB] reset mid-handshake");
    doReset();
    pulseIr(8'h20);
    intaPulse();
    checkOutput("rmh_isr_before", isr, 32'h20);
    rst_n  = 1'b0;
    inta_n = 1'b0;
    tick(1);
    inta_n = 1'b1;
    tick(1);
    rst_n  = 1'b1;
    checkOutput("rmh_irr", irr, 0);
    checkOutput("rmh_isr", isr, 0);
    checkOutput("rmh_lowest", lowest_prio, 7);
    checkOutput("rmh_int_o", int_o, 0);
    checkOutput("rmh_vec_valid", vec_valid, 0);
    ackCycle(7);

    $display("[TB] ack1 and specific eoi collision");
    doReset();
    pulseIr(8'h10);
    inta_n    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_SEOI;
    cmd_level = 3'd4;
    tick(1);
    inta_n    = 1'b1;
    cmd_valid = 1'b0;
    tick(1);
    checkOutput("col_isr", isr, 32'h10);
    checkOutput("col_irr", irr, 0);
    expVecQ.push_back(4);
    intaPulse();
    checkOutput("col_isr_after", isr, 32'h10);

    tick(2);
    checkOutput("vec_queue_drained", expVecQ.size(), 0);
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
